fft_in_loader: RTL and testbench
================================

FFT_IN_LOADER -- requirements
Module: fft_in_loader

Interface
REQ-001 SHALL have parameter W, default 15: signed width of each real and imaginary sample.
REQ-002 SHALL have parameter BITREV, default 0: when 1, sample k is stored in lane bitrev5(k); when 0, in lane k.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port arstb  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port rstb  input  1  synchronous clear, active-low; lower priority than arstb.
REQ-006 SHALL have port in_valid  input  1  input sample present.
REQ-007 SHALL have port in_ready  output  1  loader can accept a sample this cycle.
REQ-008 SHALL have port in_r  input  W  signed real part of the input sample.
REQ-009 SHALL have port in_i  input  W  signed imaginary part of the input sample.
REQ-010 SHALL have port out_valid  output  1  complete 32-point frame presented.
REQ-011 SHALL have port out_ready  input  1  downstream 32-lane pipeline register takes the frame.
REQ-012 SHALL have port out_r  output  32*W  real lanes; lane k at bits [k*W +: W].
REQ-013 SHALL have port out_i  output  32*W  imaginary lanes, same packing as out_r.
REQ-014 SHALL have port wr_idx  output  5  arrival index of the next sample in the frame being filled.

Function
REQ-015 SHALL hold two frame banks of 32 complex entries each, with a full flag per bank, a write-bank pointer wbank and a read-bank pointer rbank.
REQ-016 SHALL drive in_ready = !full[wbank], combinationally from registered state only.
REQ-017 SHALL accept a sample only on a rising edge with in_valid=1 and in_ready=1, storing it in bank wbank at lane wr_idx (BITREV=0) or lane bitrev5(wr_idx) (BITREV=1).
REQ-018 SHALL increment wr_idx modulo 32 on each accept; on the accept at wr_idx=31 it SHALL set full[wbank], toggle wbank and wrap wr_idx to 0.
REQ-019 SHALL drive out_valid = full[rbank]; out_r/out_i SHALL show bank rbank while out_valid=1 and all-zero while out_valid=0.
REQ-020 SHALL, on a rising edge with out_valid=1 and out_ready=1, clear full[rbank] and toggle rbank.
REQ-021 SHALL assert out_valid in the cycle right after the edge that accepts the 32nd sample (latency 1 cycle from final accept).
REQ-022 SHALL keep out_r/out_i/out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL, when frame completion and drain happen on the same edge, apply both; in_ready SHALL then be 1 in the following cycle if the new wbank was just drained.
REQ-024 SHALL sustain one sample per cycle indefinitely while out_ready=1 (no in_ready bubble at frame boundaries).
REQ-025 SHALL deassert in_ready when both banks are full and SHALL ignore in_valid while in_ready=0.
REQ-026 SHALL pass sample values unmodified: no scaling, rounding or sign change.
REQ-027 SHALL deliver frames in the order completed; no frame is dropped or duplicated.

Reset
REQ-028 SHALL, while arstb=0 and regardless of clk, clear both full flags, wbank, rbank, wr_idx and all bank storage to 0, giving out_valid=0, out_r=out_i=0 and in_ready=1.
REQ-029 SHALL, on a rising edge with arstb=1 and rstb=0, apply the same clear as REQ-028.
REQ-030 SHALL discard any partially filled or undrained frame on reset; the first sample accepted afterwards is arrival index 0.

Verification
REQ-031 Mid-frame arstb pulse after 10 accepts -> out_valid=0, in_ready=1, wr_idx=0, out_r=0; next 32 samples form one frame.
REQ-032 BITREV=0, ramp in_r=k, in_i=-k for k=0..31, out_ready=1 -> out_valid for one cycle after the 32nd accept; lane k = (k, -k).
REQ-033 BITREV=1, same ramp -> lane 1 = (16,-16), lane 16 = (1,-1), lane 31 = (31,-31), lane 0 = (0,0).
REQ-034 out_ready=0, stream 65 samples -> in_ready=0 after the 64th accept and the 65th sample held; raise out_ready -> frame 0 then frame 1; in_ready=1 the cycle after the first drain.
REQ-035 in_valid=1 and out_ready=1 continuously for 128 samples -> in_ready never 0; four single-cycle out_valid pulses, 32 cycles apart.
REQ-036 Both banks full, rstb=0 for one edge -> state identical to REQ-028; no stale frame appears afterwards.

Source files
------------

// File: rtl/fft_in_loader.sv
// Double-buffered 32-point complex frame loader: fills one bank sample by sample
// while the other bank is presented as a full 32-lane frame to the FFT core.
module fft_in_loader #(
   parameter int W      = 15,
   parameter int BITREV = 0
) (
   input  logic              clk,
   input  logic              arstb,
   input  logic              rstb,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [W-1:0]      in_r,
   input  logic [W-1:0]      in_i,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [32*W-1:0]   out_r,
   output logic [32*W-1:0]   out_i,
   output logic [4:0]        wr_idx
);

   localparam logic [4:0] LAST_IDX = 5'd31;

   logic [W-1:0] mem_r [2][32];
   logic [W-1:0] mem_i [2][32];

   logic [1:0]   full;
   logic [1:0]   full_nxt;
   logic         wbank;
   logic         rbank;
   logic         accept;
   logic         drain;
   logic         frame_done;
   logic [4:0]   lane;

   function automatic logic [4:0] bitrev5(input logic [4:0] v);
      logic [4:0] r;
      for (int b = 0; b < 5; b++) begin
         r[b] = v[4-b];
      end
      return r;
   endfunction

   // Handshakes depend only on registered flags, so no combinational path
   // runs from in_valid/out_ready back to in_ready/out_valid.
   assign in_ready   = !full[wbank];
   assign out_valid  = full[rbank];
   assign accept     = in_valid && in_ready;
   assign drain      = out_valid && out_ready;
   assign frame_done = accept && (wr_idx == LAST_IDX);
   assign lane       = (BITREV != 0) ? bitrev5(wr_idx) : wr_idx;

   // NOTE: every output of a combinational block gets a default first so no
   // path through the block leaves it unassigned and infers a latch.
   always_comb begin
      full_nxt = full;
      if (frame_done) full_nxt[wbank] = 1'b1;
      if (drain)      full_nxt[rbank] = 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values and simulation matches the synthesized flops.
   always_ff @(posedge clk or negedge arstb) begin
      if (!arstb) begin
         full   <= '0;
         wbank  <= 1'b0;
         rbank  <= 1'b0;
         wr_idx <= '0;
      end else if (!rstb) begin
         full   <= '0;
         wbank  <= 1'b0;
         rbank  <= 1'b0;
         wr_idx <= '0;
      end else begin
         full <= full_nxt;
         if (accept) wr_idx <= wr_idx + 5'd1;
         if (frame_done) wbank <= !wbank;
         if (drain)      rbank <= !rbank;
      end
   end

   // NOTE: the banks are deliberately reset; a cleared frame must read back as
   // zero, so this storage stays in flops rather than an unreset RAM.
   always_ff @(posedge clk or negedge arstb) begin
      if (!arstb) begin
         for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 32; k++) begin
               mem_r[b][k] <= '0;
               mem_i[b][k] <= '0;
            end
         end
      end else if (!rstb) begin
         for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 32; k++) begin
               mem_r[b][k] <= '0;
               mem_i[b][k] <= '0;
            end
         end
      end else if (accept) begin
         mem_r[wbank][lane] <= in_r;
         mem_i[wbank][lane] <= in_i;
      end
   end

   // Lanes are forced to zero whenever no frame is being offered.
   always_comb begin
      out_r = '0;
      out_i = '0;
      if (out_valid) begin
         for (int k = 0; k < 32; k++) begin
            out_r[k*W +: W] = mem_r[rbank][k];
            out_i[k*W +: W] = mem_i[rbank][k];
         end
      end
   end

endmodule

// File: tb/tb_fft_in_loader.sv
// Directed bench for fft_in_loader: runs a natural-order and a bit-reversed
// instance side by side on the same stimulus.
module tb_fft_in_loader;

   localparam int W = 15;

   logic            clk = 1'b0;
   logic            arstb = 1'b0;
   logic            rstb = 1'b1;
   logic            in_valid = 1'b0;
   logic            out_ready = 1'b0;
   logic [W-1:0]    in_r = '0;
   logic [W-1:0]    in_i = '0;

   logic            in_ready0, out_valid0, in_ready1, out_valid1;
   logic [32*W-1:0] out_r0, out_i0, out_r1, out_i1;
   logic [4:0]      wr_idx0, wr_idx1;

   int checks = 0;
   int failures = 0;

   always #5 clk = !clk;

   fft_in_loader #(.W(W), .BITREV(0)) dut0 (
      .clk(clk), .arstb(arstb), .rstb(rstb),
      .in_valid(in_valid), .in_ready(in_ready0), .in_r(in_r), .in_i(in_i),
      .out_valid(out_valid0), .out_ready(out_ready),
      .out_r(out_r0), .out_i(out_i0), .wr_idx(wr_idx0)
   );

   fft_in_loader #(.W(W), .BITREV(1)) dut1 (
      .clk(clk), .arstb(arstb), .rstb(rstb),
      .in_valid(in_valid), .in_ready(in_ready1), .in_r(in_r), .in_i(in_i),
      .out_valid(out_valid1), .out_ready(out_ready),
      .out_r(out_r1), .out_i(out_i1), .wr_idx(wr_idx1)
   );

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int lane(input logic [32*W-1:0] v, input int k);
      logic signed [W-1:0] x;
      x = v[k*W +: W];
      return int'(x);
   endfunction

   // Called just after a falling edge; returns just after the falling edge that
   // follows the accepting rising edge, with in_valid still high.
   task automatic push(input int r, input int i);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_r = W'(r);
      in_i = W'(i);
      while (!in_ready0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("push_timeout", 0, 1);
      @(negedge clk);
   endtask

   initial begin
      int pulses;
      int pulse_at [4];

      // Asynchronous reset, checked with no clock edge involved.
      #2;
      check("rst_out_valid", out_valid0, 0);
      check("rst_in_ready", in_ready0, 1);
      check("rst_wr_idx", wr_idx0, 0);
      check("rst_out_r_zero", |out_r0, 0);
      @(negedge clk);
      arstb = 1'b1;
      out_ready = 1'b1;

      // Partial frame then a mid-cycle arstb pulse.
      for (int k = 0; k < 10; k++) push(500 + k, 0);
      in_valid = 1'b0;
      check("partial_wr_idx", wr_idx0, 10);
      #2 arstb = 1'b0;
      #1;
      check("arst_out_valid", out_valid0, 0);
      check("arst_in_ready", in_ready0, 1);
      check("arst_wr_idx", wr_idx0, 0);
      check("arst_out_r_zero", |out_r0, 0);
      #1 arstb = 1'b1;
      @(negedge clk);

      // Ramp frame, checked in both lane orders.
      for (int k = 0; k < 32; k++) begin
         push(k, -k);
         if (k < 31) check("ramp_no_early_valid", out_valid0, 0);
      end
      in_valid = 1'b0;
      check("ramp_valid0", out_valid0, 1);
      check("ramp_valid1", out_valid1, 1);
      check("ramp0_l0_r", lane(out_r0, 0), 0);
      check("ramp0_l5_r", lane(out_r0, 5), 5);
      check("ramp0_l5_i", lane(out_i0, 5), -5);
      check("ramp0_l17_r", lane(out_r0, 17), 17);
      check("ramp0_l31_i", lane(out_i0, 31), -31);
      check("ramp1_l1_r", lane(out_r1, 1), 16);
      check("ramp1_l1_i", lane(out_i1, 1), -16);
      check("ramp1_l16_r", lane(out_r1, 16), 1);
      check("ramp1_l16_i", lane(out_i1, 16), -1);
      check("ramp1_l31_r", lane(out_r1, 31), 31);
      check("ramp1_l31_i", lane(out_i1, 31), -31);
      check("ramp1_l0_r", lane(out_r1, 0), 0);
      check("ramp1_l0_i", lane(out_i1, 0), 0);
      @(negedge clk);
      check("ramp_valid_one_cycle", out_valid0, 0);
      check("ramp_wr_idx_wrap", wr_idx0, 0);

      // Backpressure: fill both banks, hold the 65th sample, then drain.
      out_ready = 1'b0;
      for (int k = 0; k < 32; k++) push(100 + k, -(100 + k));
      for (int k = 0; k < 32; k++) push(200 + k, -(200 + k));
      in_valid = 1'b0;
      check("bp_in_ready_low", in_ready0, 0);
      check("bp_out_valid", out_valid0, 1);
      in_valid = 1'b1;
      in_r = W'(300);
      in_i = W'(-300);
      repeat (3) @(negedge clk);
      check("bp_held_in_ready", in_ready0, 0);
      check("bp_held_wr_idx", wr_idx0, 0);
      check("bp_f0_l0_r", lane(out_r0, 0), 100);
      check("bp_f0_l5_i", lane(out_i0, 5), -105);
      check("bp_f0_l31_r", lane(out_r0, 31), 131);
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_ready_after_drain", in_ready0, 1);
      check("bp_f1_valid", out_valid0, 1);
      check("bp_f1_l0_r", lane(out_r0, 0), 200);
      check("bp_f1_l31_i", lane(out_i0, 31), -231);
      @(negedge clk);
      in_valid = 1'b0;
      check("bp_65th_accepted", wr_idx0, 1);
      check("bp_drained", out_valid0, 0);

      // Both banks full, then a one-edge synchronous clear.
      out_ready = 1'b0;
      for (int k = 0; k < 63; k++) push(400 + k, k);
      in_valid = 1'b0;
      check("full2_in_ready", in_ready0, 0);
      check("full2_held_sample", lane(out_r0, 0), 300);
      check("full2_l1_r", lane(out_r0, 1), 400);
      rstb = 1'b0;
      @(negedge clk);
      rstb = 1'b1;
      check("srst_out_valid", out_valid0, 0);
      check("srst_in_ready", in_ready0, 1);
      check("srst_wr_idx", wr_idx0, 0);
      check("srst_out_r_zero", |out_r0, 0);
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("srst_no_stale", out_valid0, 0);

      // Continuous streaming: 128 samples, no bubbles, four one-cycle frames.
      pulses = 0;
      for (int j = 0; j < 128; j++) begin
         check("stream_in_ready", in_ready0, 1);
         push(j, -j);
         if (out_valid0) begin
            if (pulses < 4) begin
               pulse_at[pulses] = j;
               check("stream_lane7", lane(out_r0, 7), 32 * pulses + 7);
            end
            pulses++;
         end
      end
      in_valid = 1'b0;
      check("stream_pulses", pulses, 4);
      for (int p = 0; p < 4; p++) begin
         if (p < pulses) check("stream_pulse_pos", pulse_at[p], 31 + 32 * p);
      end
      @(negedge clk);
      check("stream_idle", out_valid0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
